// File: rtl/xbar_frame_serializer_pkg.sv
// Shared types and sizing helpers for the xbar frame serializer.
//   ser_state_e        : transmit FSM states
//   SER_START_BITS_MAX : largest supported start-marker length
//   SER_GAP_MAX        : largest supported idle gap length
//   ser_cnt_w()        : width of the single per-state down-counter
package xbar_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    GAP   = 2'd3
  } ser_state_e;

  localparam int SER_START_BITS_MAX = 4;
  localparam int SER_GAP_MAX        = 15;

  // The counter must hold the largest reload of any state. That is
  // START_BITS-1, WIDTH-1 or GAP_CYCLES-1. Sizing it from max(4, WIDTH, 15)
  // keeps one width regardless of which parameters are in use.
  function automatic int ser_cnt_w(input int width);
    int m;
    m = SER_GAP_MAX;
    if (SER_START_BITS_MAX > m) m = SER_START_BITS_MAX;
    if (width > m) m = width;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/xbar_frame_serializer_if.sv
// Producer-side handshake plus serial line of one serializer port.
//   in_valid / in_ready / parallel_in : word transfer into the holding register
//   serial_out                        : registered serial line, 0 when idle
//   frame_start                       : pulse on the first serial cycle of a frame
//   busy                              : FSM not idle
interface xbar_frame_serializer_if #(
  parameter int WIDTH = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out;
  logic             frame_start;
  logic             busy;

  modport master (
    output in_valid, parallel_in,
    input  in_ready, serial_out, frame_start, busy
  );

  modport slave (
    input  in_valid, parallel_in,
    output in_ready, serial_out, frame_start, busy
  );
endinterface

// File: rtl/xbar_frame_serializer_shift.sv
// Load/shift register for one frame's data bits.
//   clk, rst   : clock, synchronous active-high reset
//   load_i     : capture word_i (takes priority over shift_i)
//   shift_i    : advance to the next data bit
//   word_i     : word to capture
//   bit_nxt_o  : data bit that will be presented after this edge
module xbar_ser_shift #(
  parameter int WIDTH     = 10,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             bit_nxt_o
);

  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = word_i;
    end else if (shift_i) begin
      sh_d = (LSB_FIRST != 0) ? {1'b0, sh_q[WIDTH-1:1]} : {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= sh_d;
  end

  // The bit is taken from the next value so the top can register serial_out
  // in the same cycle as the state it belongs to.
  assign bit_nxt_o = (LSB_FIRST != 0) ? sh_d[0] : sh_d[WIDTH-1];

endmodule

// File: rtl/xbar_frame_serializer.sv
// Parallel-to-serial transmitter for one crossbar output port.
// A one-entry holding register takes words over valid/ready. Each word is sent
// as START_BITS ones, WIDTH data bits, then GAP_CYCLES zeros. A held word
// follows the previous frame with no idle cycle.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of xbar_frame_serializer_if (handshake + serial line)
//
// state | meaning
// IDLE  | no frame in flight, line low
// START | driving start-marker ones
// DATA  | driving data bits from the shifter
// GAP   | driving idle zeros after the data
module xbar_frame_serializer
  import xbar_pkg::*;
#(
  parameter int PACKET_WIDTH = 8,
  parameter int WIDTH        = PACKET_WIDTH + 2,
  parameter int LSB_FIRST    = 0,
  parameter int START_BITS   = 1,
  parameter int GAP_CYCLES   = 0
) (
  input logic               clk,
  input logic               rst,
  xbar_frame_serializer_if.slave bus
);

  localparam int CNT_W = ser_cnt_w(WIDTH);

  localparam logic [CNT_W-1:0] START_LD = (START_BITS > 0) ? CNT_W'(START_BITS - 1) : '0;
  localparam logic [CNT_W-1:0] DATA_LD  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  // A frame begins in START unless there is no marker.
  localparam ser_state_e       FIRST_ST = (START_BITS > 0) ? START : DATA;
  localparam logic [CNT_W-1:0] FIRST_LD = (START_BITS > 0) ? START_LD : DATA_LD;

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hold_v_q;
  logic [WIDTH-1:0] hold_q;
  logic             serial_q, serial_d;
  logic             fs_q, fs_d;
  logic             load, shift;
  logic             bit_nxt;
  logic             accept;

  assign bus.in_ready    = !hold_v_q && !rst;
  assign accept          = bus.in_valid && bus.in_ready;
  assign bus.serial_out  = serial_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hold_v_q) begin
          state_d = FIRST_ST;
          cnt_d   = FIRST_LD;
          load    = 1'b1;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          state_d = DATA;
          cnt_d   = DATA_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q != '0) begin
          shift = 1'b1;
          cnt_d = cnt_q - CNT_W'(1);
        end else if (GAP_CYCLES > 0) begin
          state_d = GAP;
          cnt_d   = GAP_LD;
        end else if (hold_v_q) begin
          state_d = FIRST_ST;
          cnt_d   = FIRST_LD;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (hold_v_q) begin
          state_d = FIRST_ST;
          cnt_d   = FIRST_LD;
          load    = 1'b1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    serial_d = 1'b0;
    fs_d     = load;
    unique case (state_d)
      START:   serial_d = 1'b1;
      DATA:    serial_d = bit_nxt;
      default: serial_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      serial_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      serial_q <= serial_d;
      fs_q     <= fs_d;
      if (accept) begin
        hold_v_q <= 1'b1;
        hold_q   <= bus.parallel_in;
      end else if (load) begin
        hold_v_q <= 1'b0;
      end
    end
  end

  xbar_ser_shift #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .shift_i   (shift),
    .word_i    (hold_q),
    .bit_nxt_o (bit_nxt)
  );

endmodule

// File: tb/tb_xbar_frame_serializer.sv
// Bench for xbar_frame_serializer: three instances with different framing
// parameters share clock and reset. An arithmetic model predicts accept and
// load edges per word and derives the expected line every cycle.
module tb_xbar_frame_serializer;

  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  xbar_frame_serializer_if #(.WIDTH(W)) if0 ();
  xbar_frame_serializer_if #(.WIDTH(W)) if1 ();
  xbar_frame_serializer_if #(.WIDTH(W)) if2 ();

  xbar_frame_serializer #(.PACKET_WIDTH(8)) u0 (
    .clk (clk), .rst (rst), .bus (if0.slave)
  );
  xbar_frame_serializer #(.PACKET_WIDTH(8), .LSB_FIRST(1), .START_BITS(0)) u1 (
    .clk (clk), .rst (rst), .bus (if1.slave)
  );
  xbar_frame_serializer #(.PACKET_WIDTH(8), .GAP_CYCLES(3)) u2 (
    .clk (clk), .rst (rst), .bus (if2.slave)
  );

  int p_lsb [3] = '{0, 1, 0};
  int p_sb  [3] = '{1, 0, 1};
  int p_gap [3] = '{0, 0, 3};

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] wq  [16];
  int           dly [16];
  int           off [16];
  int           acc [16];
  int           ld  [16];
  logic         cap_s [64];
  int           busy_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [W-1:0] w);
    case (d)
      0: begin if0.in_valid = v; if0.parallel_in = w; end
      1: begin if1.in_valid = v; if1.parallel_in = w; end
      default: begin if2.in_valid = v; if2.parallel_in = w; end
    endcase
  endtask

  task automatic sample(input int d, output logic s, output logic b,
                        output logic f, output logic r);
    case (d)
      0: begin s = if0.serial_out; b = if0.busy; f = if0.frame_start; r = if0.in_ready; end
      1: begin s = if1.serial_out; b = if1.busy; f = if1.frame_start; r = if1.in_ready; end
      default: begin s = if2.serial_out; b = if2.busy; f = if2.frame_start; r = if2.in_ready; end
    endcase
  endtask

  // Edge e = 0 is the first edge of the run. The producer offers word k from
  // edge off[k]. It is accepted once the holding register is free, and loaded
  // once the DUT is idle or the previous frame ends.
  task automatic run_seq(input int d, input int n, input string tag);
    int sb, gp, lsb, fl, last, p;
    logic v, es, eb, ef, er, s, b, f, r;
    logic [W-1:0] w;
    sb  = p_sb[d];
    gp  = p_gap[d];
    lsb = p_lsb[d];
    fl  = sb + W + gp;
    for (int k = 0; k < n; k++) begin
      off[k] = (k == 0) ? dly[k] : acc[k-1] + 1 + dly[k];
      acc[k] = off[k];
      if (k > 0 && acc[k] < ld[k-1] + 1) acc[k] = ld[k-1] + 1;
      ld[k] = acc[k] + 1;
      if (k > 0 && ld[k] < ld[k-1] + fl) ld[k] = ld[k-1] + fl;
    end
    last = ld[n-1] + fl + 2;
    busy_cnt = 0;
    for (int e = 0; e <= last; e++) begin
      v = 1'b0;
      w = '0;
      for (int k = 0; k < n; k++)
        if (off[k] <= e && e <= acc[k]) begin v = 1'b1; w = wq[k]; end
      drive(d, v, w);
      @(posedge clk);
      @(negedge clk);
      es = 1'b0; eb = 1'b0; ef = 1'b0; er = 1'b1;
      for (int k = 0; k < n; k++) begin
        p = e - ld[k];
        if (p >= 0 && p < fl) begin
          eb = 1'b1;
          ef = (p == 0);
          if (p < sb)          es = 1'b1;
          else if (p < sb + W) es = (lsb != 0) ? wq[k][p - sb] : wq[k][W - 1 - (p - sb)];
        end
        if (acc[k] <= e && e < ld[k]) er = 1'b0;
      end
      sample(d, s, b, f, r);
      chk({tag, "_serial"},   32'(s), 32'(es));
      chk({tag, "_busy"},     32'(b), 32'(eb));
      chk({tag, "_fstart"},   32'(f), 32'(ef));
      chk({tag, "_in_ready"}, 32'(r), 32'(er));
      if (e < 64) cap_s[e] = s;
      if (b) busy_cnt++;
    end
    drive(d, 1'b0, '0);
  endtask

  initial begin
    logic s, b, f, r;
    logic [11:0] ex12;
    logic [9:0]  ex10;
    logic [W-1:0] w_rst;

    rst = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    drive(2, 1'b0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    sample(0, s, b, f, r);
    chk("rst_in_ready_low", 32'(r), 32'd0);
    chk("rst_serial", 32'(s), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    sample(0, s, b, f, r);
    chk("idle_serial", 32'(s), 32'd0);
    chk("idle_busy", 32'(b), 32'd0);
    chk("idle_in_ready", 32'(r), 32'd1);

    // Single frame, MSB first with one start bit.
    wq[0] = 10'b1011001110; dly[0] = 0;
    run_seq(0, 1, "single");
    ex12 = 12'b1_1011001110_0;
    for (int i = 0; i < 12; i++) chk("single_seq", 32'(cap_s[1+i]), 32'(ex12[11-i]));
    chk("single_busy_len", busy_cnt, 11);

    // LSB first, no start marker.
    wq[0] = 10'h2C5; dly[0] = 0;
    run_seq(1, 1, "lsb");
    ex10 = 10'b1010001101;
    for (int i = 0; i < 10; i++) chk("lsb_seq", 32'(cap_s[1+i]), 32'(ex10[9-i]));
    chk("lsb_busy_len", busy_cnt, 10);

    // Back-to-back frames presented continuously.
    wq[0] = 10'h3FF; wq[1] = 10'h000; dly[0] = 0; dly[1] = 0;
    run_seq(0, 2, "b2b");
    for (int i = 0; i < 22; i++) chk("b2b_seq", 32'(cap_s[1+i]), (i < 12) ? 32'd1 : 32'd0);

    // Three-cycle gap between two frames.
    wq[0] = 10'h3FF; wq[1] = 10'h3FF; dly[0] = 0; dly[1] = 0;
    run_seq(2, 2, "gap");
    for (int i = 12; i < 15; i++) chk("gap_zero", 32'(cap_s[i]), 32'd0);
    chk("gap_next_start", 32'(cap_s[15]), 32'd1);
    chk("gap_busy_len", busy_cnt, 28);

    // Randomized words and producer delays on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int rep = 0; rep < 3; rep++) begin
        for (int k = 0; k < 6; k++) begin
          wq[k]  = W'($urandom);
          dly[k] = ($urandom_range(0, 3) == 0) ? 12 : int'($urandom_range(0, 3));
        end
        run_seq(d, 6, "rand");
      end
    end

    // Reset during data bit 4 with a second word held.
    w_rst = 10'h155;
    drive(0, 1'b1, w_rst);
    @(posedge clk); @(negedge clk);
    drive(0, 1'b1, 10'h0AA);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    drive(0, 1'b0, '0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    sample(0, s, b, f, r);
    chk("rstmid_bit4", 32'(s), 32'(w_rst[W-1-4]));
    chk("rstmid_held", 32'(r), 32'd0);
    chk("rstmid_busy_pre", 32'(b), 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    sample(0, s, b, f, r);
    chk("rstmid_serial", 32'(s), 32'd0);
    chk("rstmid_busy", 32'(b), 32'd0);
    chk("rstmid_in_ready_rst", 32'(r), 32'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    sample(0, s, b, f, r);
    chk("rstmid_in_ready_after", 32'(r), 32'd1);
    repeat (15) begin
      @(posedge clk); @(negedge clk);
      sample(0, s, b, f, r);
      chk("rstmid_no_frame_fs", 32'(f), 32'd0);
      chk("rstmid_no_frame_serial", 32'(s), 32'd0);
      chk("rstmid_no_frame_busy", 32'(b), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xbar_frame_serializer.md
# xbar_frame_serializer

Parametrised parallel-to-serial transmitter for the xbar transmit path. It accepts words over a valid/ready handshake into a one-entry holding register. Each word is shifted out as a frame: optional start-marker bits, then the data bits in a selectable order, then optional idle gap cycles. Back-to-back frames stream with no dead cycle when the gap is zero. It replaces the fixed-width, load-pulse serializer at each crossbar output port.

## Interface
- WIDTH, default packet_width+2: data bits per frame (≥2).
- LSB_FIRST, default 0: 0 = MSB first, 1 = LSB first.
- START_BITS, default 1 (0..4): marker cycles driving 1 before the data.
- GAP_CYCLES, default 0 (0..15): cycles driving 0 after the data.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  producer offers parallel_in.
- in_ready  out  1  holding register free; transfer on in_valid&&in_ready at a rising edge.
- parallel_in  in  WIDTH  word to send.
- serial_out  out  1  registered serial line; 0 when idle.
- frame_start  out  1  1-cycle pulse, coincident with the first serial cycle of a frame.
- busy  out  1  FSM not IDLE.

## Operation
- Reset (rst=1 at an edge): FSM→IDLE, hold_v=0, shifter=0, counters=0, serial_out=0, frame_start=0, busy=0. in_ready is forced to 0 while rst=1.
- in_ready = !hold_v && !rst, decoded from registers only.
- Holding register: written on an accepted transfer. It is cleared on the edge where the FSM loads it into the shifter. A load and a new accept on the same edge leave hold_v=1 with the new word.
- FSM states: IDLE, START, DATA, GAP.
- IDLE→START when hold_v. Goes directly to DATA if START_BITS=0. The load into the shifter happens on that edge.
- START: drives 1 for START_BITS cycles, then →DATA.
- DATA: drives one bit per cycle for WIDTH cycles. With LSB_FIRST=0 the order is bit WIDTH-1 down to bit 0; with LSB_FIRST=1 it is bit 0 up.
- After the last data bit:
  - GAP_CYCLES>0: →GAP, drives 0 for GAP_CYCLES cycles.
  - Else, if hold_v: reload from the holding register and go to START (or DATA).
  - Else: →IDLE.
- Leaving GAP: same reload-or-IDLE decision as leaving DATA.
- The frame in flight is never altered by a new accept.
- in_valid while in_ready=0: the transfer does not happen and parallel_in is ignored. The producer must hold its word.
- Counters: one counter, sized $clog2 of max(4, WIDTH, 15)+1 bits. It is reloaded per state and counts down to the last-cycle indication.

## Timing
- Accept at edge N with FSM IDLE: the first frame cycle appears on serial_out after edge N+1. frame_start=1 and busy=1 from edge N+1.
- Frame length is START_BITS+WIDTH+GAP_CYCLES cycles.
- A word already held when the previous frame's last cycle ends starts on the very next cycle, so there is zero idle between frames.
- Sustained throughput is one word per frame length. in_ready reasserts the cycle after each load.
- busy falls on the edge where the FSM enters IDLE. serial_out is 0 in that same cycle.
- rst asserted mid-frame: on that edge serial_out=0, the frame is truncated and the held word is discarded. No frame_start follows until a new accept after rst falls.

## Structure
- The xbar_pkg package holds:
  - enum ser_state_e {IDLE, START, DATA, GAP};
  - constants SER_START_BITS_MAX=4 and SER_GAP_MAX=15;
  - localparam-style function ser_cnt_w() for the counter width.
- One sub-module is natural: xbar_ser_shift (WIDTH, LSB_FIRST). It contains the load/shift register and output bit select. The FSM, holding register and counter stay in the top.

## Test plan
- Reset and idle, defaults, packet_width=8 (WIDTH=10):
  - Stimulus: rst for 3 cycles, then release with in_valid=0.
  - Required: serial_out=0, busy=0, in_ready=1 one cycle after release.
- Single frame, defaults, word 10'b1011001110 accepted at edge N:
  - After N+1, serial_out is 1 (start), then 1,0,1,1,0,0,1,1,1,0, then 0.
  - frame_start is high only in the start cycle.
  - busy is high for 11 cycles.
- LSB_FIRST=1, START_BITS=0, word 10'h2C5:
  - Serial sequence is 1,0,1,0,0,0,1,1,0,1.
  - frame_start coincides with the first data bit.
- Back-to-back, GAP_CYCLES=0, words 10'h3FF then 10'h000, both presented continuously:
  - serial_out is 1×11, then 1,0×10, with no idle cycle between frames.
  - in_ready is low while the second word is held.
- GAP_CYCLES=3, two words:
  - Exactly three 0 cycles separate the frames.
  - busy stays high across the gap.
- Reset at data bit 4 with a word held:
  - serial_out=0 and busy=0 on the next edge.
  - No further frame appears.
  - in_ready=1 one cycle after rst falls.
